// File: rtl/udp_ip_rx_parser.sv
// udp_ip_rx_parser: parses IPv4/UDP frames from MAC RX words, filters them on protocol, destination IP and port, and streams the UDP payload.
// Optional IPv4 header checksum verification is built when UDP_RX_IP_CSUM_EN is defined.
module udp_ip_rx_parser #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] mac_data,
    input  logic                  mac_valid,
    input  logic                  mac_last,
    output logic                  mac_ready,
    input  logic [31:0]           local_ip,
    input  logic [15:0]           local_port,
    output logic [DATA_WIDTH-1:0] app_data,
    output logic [3:0]            app_keep,
    output logic                  app_valid,
    output logic                  app_last,
    input  logic                  app_ready,
    output logic                  hdr_valid,
    output logic [31:0]           rx_src_ip,
    output logic [15:0]           rx_src_port,
    output logic [15:0]           rx_len,
    output logic                  err_trunc,
    output logic [CNT_WIDTH-1:0]  pkt_cnt,
    output logic [CNT_WIDTH-1:0]  drop_cnt
);
    typedef enum logic [1:0] {HDR, PAYLOAD, DRAIN, DROP} state_t;
    state_t      state;
    logic [2:0]  widx;
    logic [15:0] words_left, total_len, sport_q;
    logic [31:0] src_q;
    logic        acc, in_pay, pay_end, word_ok, csum_ok;
    logic [15:0] udp_len, rl_new, wl_new;
    logic [16:0] len_sum;
`ifdef UDP_RX_IP_CSUM_EN
    logic [15:0] csum_acc, csum_fld, csum_next;
    logic [17:0] csum_raw;
    logic [16:0] csum_f1;
    // Running ones'-complement sum over header halfwords with end-around carry
    always_comb begin
        csum_raw  = {2'b0, (widx == 3'd0) ? 16'h0 : csum_acc} + {2'b0, mac_data[31:16]} + {2'b0, mac_data[15:0]};
        csum_f1   = {1'b0, csum_raw[15:0]} + {15'b0, csum_raw[17:16]};
        csum_next = csum_f1[15:0] + {15'b0, csum_f1[16]};
        csum_ok   = csum_next == 16'hFFFF || csum_fld == 16'h0;
    end
`else
    assign csum_ok = 1'b1;
`endif
    // Per-word header checks and zero-latency payload pass-through
    always_comb begin
        in_pay    = state == PAYLOAD;
        pay_end   = words_left == 16'd1;
        mac_ready = in_pay ? app_ready : 1'b1;
        acc       = mac_valid & mac_ready;
        udp_len   = mac_data[31:16];
        len_sum   = {1'b0, udp_len} + 17'd20;
        rl_new    = udp_len - 16'd8;
        wl_new    = (rl_new + 16'd3) >> 2;
        word_ok   = widx == 3'd0 ? mac_data[31:24] == 8'h45 :
                    widx == 3'd1 ? mac_data[13:0] == 14'h0 :
                    widx == 3'd2 ? mac_data[23:16] == 8'h11 :
                    widx == 3'd4 ? mac_data == local_ip && csum_ok :
                    widx == 3'd5 ? mac_data[15:0] == local_port :
                    widx == 3'd6 ? udp_len >= 16'd8 && {1'b0, total_len} == len_sum : 1'b1;
        app_valid = in_pay & mac_valid;
        app_data  = in_pay ? mac_data : '0;
        app_last  = app_valid & (pay_end | mac_last);
        app_keep  = !in_pay ? 4'h0 : !pay_end ? 4'hF :
                    rx_len[1:0] == 2'd1 ? 4'h8 : rx_len[1:0] == 2'd2 ? 4'hC :
                    rx_len[1:0] == 2'd3 ? 4'hE : 4'hF;
    end
    // Frame FSM, header latches, pulses and statistics
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= HDR;
            widx        <= 3'd0;
            words_left  <= '0;
            total_len   <= '0;
            src_q       <= '0;
            sport_q     <= '0;
            rx_src_ip   <= '0;
            rx_src_port <= '0;
            rx_len      <= '0;
            hdr_valid   <= 1'b0;
            err_trunc   <= 1'b0;
            pkt_cnt     <= '0;
            drop_cnt    <= '0;
`ifdef UDP_RX_IP_CSUM_EN
            csum_acc    <= '0;
            csum_fld    <= '0;
`endif
        end else begin
            hdr_valid <= 1'b0;
            err_trunc <= 1'b0;
            if (acc) begin
                case (state)
                    HDR: begin
                        if (widx == 3'd0) total_len <= mac_data[15:0];
                        if (widx == 3'd3) src_q <= mac_data;
                        if (widx == 3'd5) sport_q <= mac_data[31:16];
`ifdef UDP_RX_IP_CSUM_EN
                        csum_acc <= csum_next;
                        if (widx == 3'd2) csum_fld <= mac_data[15:0];
`endif
                        if (!word_ok || (mac_last && widx != 3'd6)) begin
                            widx  <= 3'd0;
                            state <= mac_last ? HDR : DROP;
                            if (mac_last) drop_cnt <= drop_cnt + CNT_WIDTH'(1);
                        end else if (widx == 3'd6) begin
                            widx        <= 3'd0;
                            rx_src_ip   <= src_q;
                            rx_src_port <= sport_q;
                            rx_len      <= rl_new;
                            words_left  <= wl_new;
                            hdr_valid   <= 1'b1;
                            pkt_cnt     <= pkt_cnt + CNT_WIDTH'(1);
                            err_trunc   <= mac_last && rl_new != 16'd0;
                            state       <= mac_last ? HDR : rl_new == 16'd0 ? DRAIN : PAYLOAD;
                        end else begin
                            widx <= widx + 3'd1;
                        end
                    end
                    PAYLOAD: begin
                        words_left <= words_left - 16'd1;
                        err_trunc  <= mac_last && !pay_end;
                        if (pay_end || mac_last) state <= (pay_end && !mac_last) ? DRAIN : HDR;
                    end
                    DRAIN: state <= mac_last ? HDR : DRAIN;
                    default: begin
                        if (mac_last) drop_cnt <= drop_cnt + CNT_WIDTH'(1);
                        state <= mac_last ? HDR : DROP;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_udp_ip_rx_parser.sv
// tb_udp_ip_rx_parser: randomized frames checked against a frame-level reference model of the UDP/IPv4 receive parser.
module tb_udp_ip_rx_parser;
    localparam logic [31:0] LIP   = 32'hC0A8_0164;
    localparam logic [15:0] LPORT = 16'd5000;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic [31:0] mac_data = '0;
    logic        mac_valid = 1'b0, mac_last = 1'b0, mac_ready;
    logic [31:0] app_data;
    logic [3:0]  app_keep;
    logic        app_valid, app_last, app_ready = 1'b1;
    logic        hdr_valid, err_trunc;
    logic [31:0] rx_src_ip;
    logic [15:0] rx_src_port, rx_len, pkt_cnt, drop_cnt;

    udp_ip_rx_parser dut (
        .clk(clk), .rst_n(rst_n), .mac_data(mac_data), .mac_valid(mac_valid), .mac_last(mac_last),
        .mac_ready(mac_ready), .local_ip(LIP), .local_port(LPORT), .app_data(app_data), .app_keep(app_keep),
        .app_valid(app_valid), .app_last(app_last), .app_ready(app_ready), .hdr_valid(hdr_valid),
        .rx_src_ip(rx_src_ip), .rx_src_port(rx_src_port), .rx_len(rx_len), .err_trunc(err_trunc),
        .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    logic [31:0] frm[$];
    logic [36:0] exp_app[$];
    logic [63:0] exp_hdr[$];
    logic [3:0]  kt[4] = '{4'hF, 4'h8, 4'hC, 4'hE};
    int n_chk = 0, n_pass = 0, exp_pkt = 0, exp_drop = 0, exp_trunc = 0, seen_trunc = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Builds a frame: bad selects 0 ok,1 ver,2 frag,3 proto,4 dst,5 port,6 total_len,7 csum,8 udp_len<8
    task automatic build(input int ulen, input int npw, input int bad);
        int s, ul;
        logic [31:0] w;
        ul = (bad == 8) ? 4 : ulen;
        frm.delete();
        frm.push_back({(bad == 1) ? 8'h46 : 8'h45, 8'h00, 16'(ul + ((bad == 6) ? 21 : 20))});
        frm.push_back({16'($urandom), (bad == 2) ? 16'h2000 : 16'h4000});
        frm.push_back({8'h40, (bad == 3) ? 8'h06 : 8'h11, 16'h0});
        frm.push_back($urandom);
        frm.push_back((bad == 4) ? LIP ^ 32'h100 : LIP);
        frm.push_back({16'($urandom), (bad == 5) ? LPORT + 16'd1 : LPORT});
        frm.push_back({16'(ul), 16'($urandom)});
        s = 0;
        for (int i = 0; i < 5; i++) begin
            w = frm[i];
            s += int'(w[31:16]) + int'(w[15:0]);
        end
        while (s > 'hFFFF) s = (s & 'hFFFF) + (s >> 16);
        w = frm[2];
        w[15:0] = ~s[15:0];
        frm[2] = w;
        if (bad == 7) frm[3] = frm[3] ^ 32'h0001_0000;
        for (int i = 0; i < npw; i++) frm.push_back($urandom);
    endtask

    // Derives expected payload, header fields and counters straight from the frame contents
    task automatic model();
        int n, ul, rl, nw, av, m, s;
        bit ok;
        logic [31:0] w0, w1, w2, w5;
        n  = frm.size();
        ok = n >= 7;
        if (ok) begin
            w0 = frm[0]; w1 = frm[1]; w2 = frm[2]; w5 = frm[5];
            ul = int'(frm[6] >> 16);
            ok = w0[31:24] == 8'h45 && w1[13:0] == 14'h0 && w2[23:16] == 8'h11 && frm[4] == LIP &&
                 w5[15:0] == LPORT && ul >= 8 && int'(w0[15:0]) == ul + 20;
`ifdef UDP_RX_IP_CSUM_EN
            s = 0;
            for (int i = 0; i < 5; i++) s += int'(frm[i] >> 16) + int'(frm[i] & 32'hFFFF);
            while (s > 'hFFFF) s = (s & 'hFFFF) + (s >> 16);
            if (s != 'hFFFF && w2[15:0] != 16'h0) ok = 0;
`else
            s = 0;
`endif
        end
        if (!ok) exp_drop++;
        else begin
            exp_pkt++;
            rl = ul - 8;
            exp_hdr.push_back({frm[3], w5[31:16], 16'(rl)});
            nw = (rl + 3) / 4;
            av = n - 7;
            m  = (nw < av) ? nw : av;
            if (av < nw) exp_trunc++;
            for (int i = 0; i < m; i++)
                exp_app.push_back({i == m - 1, (i == nw - 1) ? kt[rl % 4] : 4'hF, frm[7 + i]});
        end
    endtask

    task automatic sample();
        logic [36:0] e;
        logic [63:0] h;
        if (app_valid && app_ready) begin
            if (exp_app.size() == 0) check("app_extra", 64'(app_valid), 64'd0);
            else begin
                e = exp_app.pop_front();
                check("app_data", app_data, e[31:0]);
                check("app_keep", app_keep, e[35:32]);
                check("app_last", app_last, e[36]);
            end
        end
        if (hdr_valid) begin
            if (exp_hdr.size() == 0) check("hdr_extra", 64'(hdr_valid), 64'd0);
            else begin
                h = exp_hdr.pop_front();
                check("rx_src_ip", rx_src_ip, h[63:32]);
                check("rx_src_port", rx_src_port, h[31:16]);
                check("rx_len", rx_len, h[15:0]);
            end
        end
        if (err_trunc) seen_trunc++;
    endtask

    task automatic send_word(input logic [31:0] d, input logic l);
        bit v, fire;
        int tries;
        tries = 0;
        do begin
            @(negedge clk);
            v = ($urandom % 4) != 0;
            mac_valid = v;
            mac_data  = v ? d : $urandom;
            mac_last  = v ? l : 1'($urandom);
            app_ready = ($urandom % 4) != 0;
            #4;
            sample();
            fire = v && mac_ready;
            @(posedge clk);
            tries++;
        end while (!fire && tries < 300);
        if (!fire) check("word_accept_timeout", 64'(fire), 64'd1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            mac_valid = 1'b0;
            mac_last  = 1'b0;
            app_ready = 1'b1;
            #4;
            sample();
            @(posedge clk);
        end
    endtask

    task automatic send_frame();
        model();
        for (int i = 0; i < frm.size(); i++) send_word(frm[i], i == frm.size() - 1);
    endtask

    task automatic chk_cnt(input string tag);
        idle(3);
        check({tag, "_pkt_cnt"}, pkt_cnt, exp_pkt);
        check({tag, "_drop_cnt"}, drop_cnt, exp_drop);
        check({tag, "_trunc"}, seen_trunc, exp_trunc);
        check({tag, "_pending"}, exp_app.size() + exp_hdr.size(), 0);
    endtask

    initial begin
        int ul, nw, npw, mode, bad;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mac_ready", mac_ready, 1);
        check("rst_app_valid", app_valid, 0);
        check("rst_hdr_valid", hdr_valid, 0);
        check("rst_rx_len", rx_len, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_pkt_cnt", pkt_cnt, 0);
        check("rel_drop_cnt", drop_cnt, 0);
        check("rel_err_trunc", err_trunc, 0);

        build(16, 2, 0);
        frm[7] = 32'hAABBCCDD;
        frm[8] = 32'h11223344;
        send_frame();
        chk_cnt("basic");

        build(13, 4, 0);
        send_frame();
        chk_cnt("pad");

        build(16, 2, 4);
        send_frame();
        build(16, 2, 0);
        send_frame();
        chk_cnt("dst_b2b");

        build(20, 2, 0);
        send_frame();
        build(12, 1, 0);
        send_frame();
        chk_cnt("trunc");

        build(24, 4, 0);
        model();
        for (int i = 0; i < 8; i++) send_word(frm[i], 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mac_valid = 1'b1;
            mac_data  = frm[8];
            mac_last  = 1'b0;
            app_ready = 1'b0;
            #4;
            check("mac_ready_backpressure", mac_ready, 0);
            sample();
            @(posedge clk);
        end
        for (int i = 8; i < frm.size(); i++) send_word(frm[i], i == frm.size() - 1);
        chk_cnt("stall");

        build(16, 2, 7);
        send_frame();
        chk_cnt("csum");

        build(16, 2, 0);
        while (frm.size() > 4) void'(frm.pop_back());
        send_frame();
        chk_cnt("runt");

        build(8, 0, 0);
        send_frame();
        build(8, 2, 0);
        send_frame();
        chk_cnt("zero_len");

        for (int f = 0; f < 40; f++) begin
            bad  = ($urandom % 2) ? 0 : 1 + int'($urandom % 8);
            ul   = 8 + int'($urandom % 40);
            nw   = (ul - 8 + 3) / 4;
            mode = int'($urandom % 4);
            npw  = (mode == 0 && nw > 1) ? 1 + int'($urandom % (nw - 1)) : nw + int'($urandom % 3);
            build(ul, npw, bad);
            if (mode == 1) begin
                npw = 1 + int'($urandom % 6);
                while (frm.size() > npw) void'(frm.pop_back());
            end
            send_frame();
            idle(int'($urandom % 3));
        end
        chk_cnt("random");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
